// File: rtl/dma_axi_arb.sv
// dma_axi_arb: per-cycle arbiter between the vector DMA lane ports and the
// AXI slave request channel in front of the banked scratchpad. AXI requests
// are deferred by DMA traffic for at most AXI_WAIT_MAX cycles. AXI reads are
// tracked through the bank latency and returned as a one-cycle pulse.
// Optional feature macro: DMA_AXI_ARB_STATS_EN (grant/stall statistics).
module dma_axi_arb #(
    parameter int ADDRWIDTH    = 11,
    parameter int NUMLANES     = 8,
    parameter int WIDTH        = 16,
    parameter int MEMLAT       = 1,
    parameter int AXI_WAIT_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUMLANES*ADDRWIDTH-1:0] dma_addr,
    input  logic [NUMLANES*WIDTH-1:0]     dma_data,
    input  logic [NUMLANES-1:0]           dma_rden,
    input  logic [NUMLANES-1:0]           dma_wren,
    output logic                          dma_stall,
    output logic [NUMLANES*WIDTH-1:0]     dma_out,
    input  logic                          axi_req_valid,
    input  logic                          axi_req_type,
    input  logic [ADDRWIDTH-1:0]          axi_addr,
    input  logic [NUMLANES*WIDTH-1:0]     axi_wdata,
    output logic                          axi_req_ready,
    output logic                          axi_rvalid,
    output logic [NUMLANES*WIDTH-1:0]     axi_rdata,
    output logic [NUMLANES*ADDRWIDTH-1:0] mem_addr,
    output logic [NUMLANES*WIDTH-1:0]     mem_data,
    output logic [NUMLANES-1:0]           mem_rden,
    output logic [NUMLANES-1:0]           mem_wren,
    input  logic [NUMLANES*WIDTH-1:0]     mem_readdata,
    output logic [31:0]                   stat_axi_grants,
    output logic [31:0]                   stat_dma_stalls
);

    // Handshake: an AXI request is taken in exactly the cycle where
    // axi_req_valid and axi_req_ready are both high; a DMA request is taken in
    // every cycle where it is active and dma_stall is low. Read responses have
    // no backpressure: axi_rvalid is a single-cycle pulse that must be consumed.

    localparam int WW = $clog2(AXI_WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(AXI_WAIT_MAX);

    logic              dma_active;
    logic              grant_axi;
    logic [WW-1:0]     wait_cnt;
    logic [MEMLAT-1:0] tag_q;
    logic              tag_in;

    assign dma_active = |(dma_rden | dma_wren);
    assign grant_axi  = axi_req_valid & (~dma_active | (wait_cnt == WAIT_MAX));
    assign tag_in     = grant_axi & ~axi_req_type;
    assign dma_out    = mem_readdata;

    // Starvation counter: counts consecutive deferred cycles of a pending AXI request.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!axi_req_valid || grant_axi) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Bank request mux: AXI drives all lanes with consecutive addresses when granted.
    always_comb begin
        mem_addr      = dma_addr;
        mem_data      = dma_data;
        mem_rden      = dma_rden;
        mem_wren      = dma_wren;
        axi_req_ready = 1'b0;
        dma_stall     = 1'b0;
        if (grant_axi) begin
            for (int i = 0; i < NUMLANES; i++) begin
                mem_addr[i*ADDRWIDTH +: ADDRWIDTH] = axi_addr + ADDRWIDTH'(i);
            end
            mem_data      = axi_wdata;
            mem_rden      = {NUMLANES{~axi_req_type}};
            mem_wren      = {NUMLANES{axi_req_type}};
            axi_req_ready = 1'b1;
            dma_stall     = dma_active;
        end
    end

    // Read tag pipeline and response capture; a tag leaving the pipe marks valid bank data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q      <= '0;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < MEMLAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            axi_rvalid <= tag_q[MEMLAT-1];
            if (tag_q[MEMLAT-1]) begin
                axi_rdata <= mem_readdata;
            end
        end
    end

`ifdef DMA_AXI_ARB_STATS_EN
    // Saturating statistics counters for AXI grants and DMA stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_axi_grants <= '0;
            stat_dma_stalls <= '0;
        end else begin
            if (grant_axi && (stat_axi_grants != 32'hFFFF_FFFF)) begin
                stat_axi_grants <= stat_axi_grants + 32'd1;
            end
            if (dma_stall && (stat_dma_stalls != 32'hFFFF_FFFF)) begin
                stat_dma_stalls <= stat_dma_stalls + 32'd1;
            end
        end
    end
`else
    assign stat_axi_grants = '0;
    assign stat_dma_stalls = '0;
`endif

endmodule

// File: tb/tb_dma_axi_arb.sv
// Directed bench for dma_axi_arb with hand-computed expected values.
// Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
module tb_dma_axi_arb;

    localparam int AW = 11;
    localparam int NL = 8;
    localparam int W  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NL*AW-1:0] dma_addr;
    logic [NL*W-1:0]  dma_data;
    logic [NL-1:0]    dma_rden;
    logic [NL-1:0]    dma_wren;
    logic             dma_stall;
    logic [NL*W-1:0]  dma_out;
    logic             axi_req_valid;
    logic             axi_req_type;
    logic [AW-1:0]    axi_addr;
    logic [NL*W-1:0]  axi_wdata;
    logic             axi_req_ready;
    logic             axi_rvalid;
    logic [NL*W-1:0]  axi_rdata;
    logic [NL*AW-1:0] mem_addr;
    logic [NL*W-1:0]  mem_data;
    logic [NL-1:0]    mem_rden;
    logic [NL-1:0]    mem_wren;
    logic [NL*W-1:0]  mem_readdata;
    logic [31:0]      stat_axi_grants;
    logic [31:0]      stat_dma_stalls;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NL*W-1:0] exp_q[$];
    logic [NL*W-1:0] rd_pat[4];
    logic [NL*W-1:0] exp_d;
    logic [31:0]     exp_stat;

    dma_axi_arb dut (
        .clk(clk), .reset(reset),
        .dma_addr(dma_addr), .dma_data(dma_data), .dma_rden(dma_rden), .dma_wren(dma_wren),
        .dma_stall(dma_stall), .dma_out(dma_out),
        .axi_req_valid(axi_req_valid), .axi_req_type(axi_req_type), .axi_addr(axi_addr),
        .axi_wdata(axi_wdata), .axi_req_ready(axi_req_ready),
        .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_readdata(mem_readdata),
        .stat_axi_grants(stat_axi_grants), .stat_dma_stalls(stat_dma_stalls)
    );

    // Clock generation
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge (input drive point)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge (sample point)
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        dma_addr      = '0;
        dma_data      = '0;
        dma_rden      = '0;
        dma_wren      = '0;
        axi_req_valid = 1'b0;
        axi_req_type  = 1'b0;
        axi_addr      = '0;
        axi_wdata     = '0;
        mem_readdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // DMA reads every cycle while an AXI read is held; AXI wins on cycle 4
    task automatic starve_run(input string nm);
        dma_rden      = 8'hFF;
        dma_addr      = 88'h0123456789ABCDEF012345;
        dma_data      = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        axi_req_valid = 1'b1;
        axi_req_type  = 1'b0;
        axi_addr      = 11'h100;
        for (int c = 1; c <= 3; c++) begin
            sample();
            check({nm, "_ready_wait"}, axi_req_ready, 1'b0);
            check({nm, "_addr_dma"}, mem_addr, 88'h0123456789ABCDEF012345);
            check({nm, "_stall_wait"}, dma_stall, 1'b0);
            tick();
        end
        sample();
        check({nm, "_ready_c4"}, axi_req_ready, 1'b1);
        check({nm, "_stall_c4"}, dma_stall, 1'b1);
        check({nm, "_addr0_c4"}, mem_addr[AW-1:0], 11'h100);
        tick();
        axi_req_valid = 1'b0;
        sample();
        check({nm, "_ready_c5"}, axi_req_ready, 1'b0);
        check({nm, "_stall_c5"}, dma_stall, 1'b0);
        check({nm, "_waitcnt_c5"}, dut.wait_cnt, 2'd0);
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        rd_pat[0] = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
        rd_pat[1] = 128'hDEAD_BEEF_0001_0002_0003_0004_0005_0006;
        rd_pat[2] = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0;
        rd_pat[3] = 128'h8000_4000_2000_1000_0800_0400_0200_0100;

        // Reset state
        do_reset();
        sample();
        check("rst_rvalid", axi_rvalid, 1'b0);
        check("rst_rdata", axi_rdata, 128'h0);
        check("rst_stat_grants", stat_axi_grants, 32'h0);
        check("rst_waitcnt", dut.wait_cnt, 2'd0);
        tick();

        // AXI write with address wrap, no DMA
        axi_req_valid = 1'b1;
        axi_req_type  = 1'b1;
        axi_addr      = 11'h7FC;
        axi_wdata     = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        sample();
        check("wr_ready", axi_req_ready, 1'b1);
        check("wr_addr", mem_addr,
              {11'h003, 11'h002, 11'h001, 11'h000, 11'h7FF, 11'h7FE, 11'h7FD, 11'h7FC});
        check("wr_wren", mem_wren, 8'hFF);
        check("wr_rden", mem_rden, 8'h00);
        check("wr_data", mem_data, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978);
        check("wr_stall", dma_stall, 1'b0);
        tick();

        // Single AXI read, response two cycles after the grant
        axi_req_type = 1'b0;
        axi_addr     = 11'h010;
        sample();
        check("rd_ready", axi_req_ready, 1'b1);
        check("rd_rden", mem_rden, 8'hFF);
        check("rd_wren", mem_wren, 8'h00);
        tick();
        idle_inputs();
        mem_readdata = {8{16'hA5A5}};
        sample();
        check("rd_rvalid_t1", axi_rvalid, 1'b0);
        check("dma_out_pass", dma_out, {8{16'hA5A5}});
        tick();
        mem_readdata = 128'h0;
        sample();
        check("rd_rvalid_t2", axi_rvalid, 1'b1);
        check("rd_rdata_t2", axi_rdata, {8{16'hA5A5}});
        tick();
        sample();
        check("rd_rvalid_t3", axi_rvalid, 1'b0);
        check("rd_rdata_hold", axi_rdata, {8{16'hA5A5}});
        tick();

        // Starvation scenario twice from a clean reset
        do_reset();
        starve_run("stv1");
        starve_run("stv2");
        sample();
`ifdef DMA_AXI_ARB_STATS_EN
        exp_stat = 32'd2;
`else
        exp_stat = 32'd0;
`endif
        check("stat_grants", stat_axi_grants, exp_stat);
        check("stat_stalls", stat_dma_stalls, exp_stat);
        tick();

        // Four back-to-back AXI reads: data for read k returns one cycle after its grant
        for (int c = 0; c <= 6; c++) begin
            axi_req_valid = (c <= 3);
            axi_req_type  = 1'b0;
            axi_addr      = AW'(8 * c);
            mem_readdata  = (c >= 1 && c <= 4) ? rd_pat[c-1] : 128'h0;
            sample();
            if (c <= 3) begin
                check("b2b_ready", axi_req_ready, 1'b1);
                exp_q.push_back(rd_pat[c]);
            end
            if (c >= 2 && c <= 5) begin
                exp_d = exp_q.pop_front();
                check("b2b_rvalid", axi_rvalid, 1'b1);
                check("b2b_rdata", axi_rdata, exp_d);
            end
            if (c == 6) check("b2b_rvalid_end", axi_rvalid, 1'b0);
            tick();
        end
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        idle_inputs();

        // Reset in flight drops the pending read response
        axi_req_valid = 1'b1;
        axi_req_type  = 1'b0;
        sample();
        check("rr_ready", axi_req_ready, 1'b1);
        tick();
        axi_req_valid = 1'b0;
        reset         = 1'b1;
        mem_readdata  = {8{16'h5A5A}};
        tick();
        reset        = 1'b0;
        mem_readdata = 128'h0;
        sample();
        check("rr_rvalid_t2", axi_rvalid, 1'b0);
        check("rr_rdata_t2", axi_rdata, 128'h0);
        tick();
        sample();
        check("rr_rvalid_t3", axi_rvalid, 1'b0);
        check("rr_rdata_t3", axi_rdata, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_axi_arb.md
# dma_axi_arb

Cycle-level arbiter and sequencer for the shared banked vector scratchpad. It sits between the vector DMA lane ports, the AXI slave request channel and the memory banks. It grants each cycle to either DMA or AXI, with bounded AXI starvation, and drives the selected lane-wide request onto the banks. It also tracks in-flight AXI reads through the memory read latency and returns them as a `axi_rvalid`/`axi_rdata` response.

## Interface
- `ADDRWIDTH`, 11: per-bank word address width.
- `NUMLANES`, 8: number of banks/lanes.
- `WIDTH`, 16: data width per lane.
- `MEMLAT`, 1: bank read latency in cycles, ≥1.
- `AXI_WAIT_MAX`, 3: maximum consecutive cycles a pending AXI request is deferred by DMA traffic, ≥1.
- `clk` in 1: clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `dma_addr` in NUMLANES*ADDRWIDTH: per-lane DMA address.
- `dma_data` in NUMLANES*WIDTH: per-lane DMA write data.
- `dma_rden`, `dma_wren` in NUMLANES each: per-lane DMA enables.
- `dma_stall` out 1: DMA request this cycle not accepted; hold and retry.
- `dma_out` out NUMLANES*WIDTH: `mem_readdata` passthrough.
- `axi_req_valid` in 1: AXI request pending.
- `axi_req_type` in 1: 1 = write, 0 = read.
- `axi_addr` in ADDRWIDTH: base address.
- `axi_wdata` in NUMLANES*WIDTH: write data.
- `axi_req_ready` out 1: AXI request accepted this cycle.
- `axi_rvalid` out 1: one-cycle read response pulse.
- `axi_rdata` out NUMLANES*WIDTH: read response data; held until the next response.
- `mem_addr` out NUMLANES*ADDRWIDTH: bank addresses.
- `mem_data` out NUMLANES*WIDTH: bank write data.
- `mem_rden`, `mem_wren` out NUMLANES each: bank enables.
- `mem_readdata` in NUMLANES*WIDTH: bank read data, valid MEMLAT cycles after `mem_rden`.
- `stat_axi_grants`, `stat_dma_stalls` out 32 each: statistics counters (see Configuration).

## Operation
- `dma_active` = |(`dma_rden` | `dma_wren`).
- `grant_axi` = `axi_req_valid` & (!`dma_active` | `wait_cnt` == AXI_WAIT_MAX).
  - Combinational from inputs and the registered `wait_cnt`.
- `wait_cnt` (clog2(AXI_WAIT_MAX+1) bits, register):
  - Increments when `axi_req_valid` & !`grant_axi`.
  - Clears to 0 on `grant_axi` or when `axi_req_valid` = 0.
  - Never exceeds AXI_WAIT_MAX.
- Outputs when `grant_axi` = 1:
  - `axi_req_ready` = 1.
  - Lane i `mem_addr` = `axi_addr` + i, truncated to ADDRWIDTH, so addresses wrap modulo 2^ADDRWIDTH.
  - `mem_data` = `axi_wdata`.
  - All lanes: `mem_wren` = `axi_req_type`, `mem_rden` = !`axi_req_type`.
  - `dma_stall` = `dma_active`.
- Outputs otherwise:
  - `mem_*` carry the `dma_*` inputs unchanged.
  - `axi_req_ready` = 0, `dma_stall` = 0.
- Read tag pipeline: MEMLAT-deep shift register of 1-bit tags. Tag in = `grant_axi` & !`axi_req_type`.
  - When a tag exits with value 1: `axi_rdata` <= `mem_readdata` and `axi_rvalid` = 1 that cycle (registered).
  - DMA read data always passes through `dma_out`; DMA tracks its own latency.
- Back-to-back AXI reads produce back-to-back `axi_rvalid` pulses.
- There is no response backpressure; the consumer must accept every pulse.
- Reset values:
  - `wait_cnt` = 0.
  - Tag pipeline cleared.
  - `axi_rvalid` = 0, `axi_rdata` = 0.
  - Statistics counters = 0.
- Reset asserted mid-read: in-flight reads are dropped and no `axi_rvalid` is produced for them.
- Combinational outputs follow the inputs during reset.

## Timing
- Request to bank: combinational, same cycle as the grant.
- AXI read: `axi_rvalid` asserts exactly MEMLAT+1 cycles after the `axi_req_ready` cycle (MEMLAT of bank latency plus one capture register).
- Worst-case AXI wait under continuous DMA traffic: AXI_WAIT_MAX cycles. The grant occurs on cycle AXI_WAIT_MAX+1 after the request is raised.
- DMA loses at most one cycle per AXI grant.
- A new request and a returning response may occur in the same cycle; they are independent.

## Configuration
- `DMA_AXI_ARB_STATS_EN` defined:
  - `stat_axi_grants` increments on every `grant_axi`.
  - `stat_dma_stalls` increments on every `dma_stall` cycle.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Macro undefined: both ports are tied to 0 and no counter logic is built. The port list is unchanged.

## Test plan
- AXI write, no DMA, `axi_addr` = 11'h7FC:
  - `axi_req_ready` = 1 the same cycle.
  - `mem_addr` lanes 0..7 = 7FC, 7FD, 7FE, 7FF, 000, 001, 002, 003.
  - `mem_wren` = 8'hFF, `mem_rden` = 0.
- AXI read, MEMLAT = 1, bank returns 128'hA5…:
  - `axi_rvalid` pulses one cycle, 2 cycles after the grant.
  - `axi_rdata` = 128'hA5… and holds afterwards.
- Continuous DMA reads plus AXI read held, AXI_WAIT_MAX = 3:
  - Cycles 1–3: DMA drives the banks, `axi_req_ready` = 0.
  - Cycle 4: AXI is granted and `dma_stall` = 1.
  - Cycle 5: DMA resumes and `wait_cnt` = 0.
- Four back-to-back AXI reads with no DMA: four consecutive `axi_rvalid` pulses with data in order.
- AXI read granted, then `reset` asserted for 1 cycle before the response: no `axi_rvalid` is produced and `axi_rdata` = 0.
- With `DMA_AXI_ARB_STATS_EN`, run the starvation scenario twice: `stat_axi_grants` = 2 and `stat_dma_stalls` = 2. Without the macro, both read 0.
